// File: rtl/mesi_isc_pkg.sv
// Shared definitions for the MESI inter-cache coherence (ISC) unit.
//   - Coherence-bus command codes driven on the per-CPU command buses.
//   - Broadcast request type codes carried by the broadcast FIFO.
//   - State encoding of the broadcast sequencer, shared so other code can
//     name the states.
package mesi_isc_pkg;

    localparam logic [2:0] CBUS_CMD_NOP      = 3'd0;
    localparam logic [2:0] CBUS_CMD_WR_SNOOP = 3'd1;
    localparam logic [2:0] CBUS_CMD_RD_SNOOP = 3'd2;
    localparam logic [2:0] CBUS_CMD_EN_WR    = 3'd3;
    localparam logic [2:0] CBUS_CMD_EN_RD    = 3'd4;

    localparam logic [1:0] BROAD_TYPE_NOP = 2'd0;
    localparam logic [1:0] BROAD_TYPE_WR  = 2'd1;
    localparam logic [1:0] BROAD_TYPE_RD  = 2'd2;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_SNOOP  = 2'd1,
        SEQ_ENABLE = 2'd2,
        SEQ_RETIRE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mesi_isc_broad_watchdog.sv
// Phase watchdog for the broadcast sequencer.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   i_clr       - restart the count (phase change); wins over i_inc
//   i_inc       - count this cycle (sequencer is waiting on acknowledges)
//   o_expire    - combinational: this edge completes TIMEOUT_CYCLES counts
//   o_timeout   - sticky error flag, cleared only by rst
module mesi_isc_broad_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire,
    output logic o_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Expiry is flagged on the edge that would take the count to the limit,
    // so the waiting phase lasts exactly TIMEOUT_CYCLES cycles.
    assign o_expire  = i_inc && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_timeout = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (o_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_isc_broad_sequencer.sv
// Broadcast sequencer of the MESI ISC unit. Pops one broadcast entry at a
// time, snoops the three non-source CPUs, then enables the source CPU and
// retires the entry with a one-cycle pop strobe.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   broad_valid_i/type/cpu_id/id/addr - head of the broadcast FIFO
//   broad_pop_o                 - one-cycle pop strobe to the FIFO
//   cbus_addr_o                 - address of the active broadcast
//   cbus_cmd3_o..cbus_cmd0_o    - per-CPU coherence commands
//   cbus_ack3_i..cbus_ack0_i    - per-CPU command acknowledges
//   active_id_o                 - id of the entry in flight
//   busy_o                      - sequencer not idle
//   timeout_o                   - sticky watchdog error
module mesi_isc_broad_sequencer
    import mesi_isc_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 5,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        broad_valid_i,
    input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
    input  logic [1:0]                  broad_cpu_id_i,
    input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
    input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
    output logic                        broad_pop_o,
    output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
    output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd3_o,
    output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd2_o,
    output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd1_o,
    output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd0_o,
    input  logic                        cbus_ack3_i,
    input  logic                        cbus_ack2_i,
    input  logic                        cbus_ack1_i,
    input  logic                        cbus_ack0_i,
    output logic [BROAD_ID_WIDTH-1:0]   active_id_o,
    output logic                        busy_o,
    output logic                        timeout_o
);

    seq_state_e                          r_state, w_state_nxt;
    logic [3:0]                          r_mask, w_mask_nxt;
    logic [3:0]                          w_ack;
    logic                                r_is_rd, w_is_rd_nxt;
    logic [1:0]                          r_src, w_src_nxt;
    logic                                w_latch;
    logic                                w_type_wr, w_type_rd;
    logic [ADDR_WIDTH-1:0]               r_addr;
    logic [BROAD_ID_WIDTH-1:0]           r_id;
    logic                                r_pop;
    logic [3:0][CBUS_CMD_WIDTH-1:0]      r_cmd, w_cmd_nxt;
    logic                                w_wd_clr, w_wd_inc, w_wd_expire;

    assign w_ack     = {cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i};
    assign w_type_wr = (broad_type_i == BROAD_TYPE_WIDTH'(BROAD_TYPE_WR));
    assign w_type_rd = (broad_type_i == BROAD_TYPE_WIDTH'(BROAD_TYPE_RD));

    assign w_wd_clr = (w_state_nxt != r_state);
    assign w_wd_inc = (r_state == SEQ_SNOOP) || (r_state == SEQ_ENABLE);

    mesi_isc_broad_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_wd_clr),
        .i_inc    (w_wd_inc),
        .o_expire (w_wd_expire),
        .o_timeout(timeout_o)
    );

    // Next state and ack tracking.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_latch     = 1'b0;
        unique case (r_state)
            SEQ_IDLE: begin
                if (broad_valid_i) begin
                    if (w_type_wr || w_type_rd) begin
                        w_latch     = 1'b1;
                        w_mask_nxt  = 4'hF & ~(4'b0001 << broad_cpu_id_i);
                        w_state_nxt = SEQ_SNOOP;
                    end else begin
                        // NOP / reserved types are dropped without bus traffic.
                        w_state_nxt = SEQ_RETIRE;
                    end
                end
            end
            SEQ_SNOOP: begin
                // Acks from CPUs no longer pending fall out of the AND.
                w_mask_nxt = r_mask & ~w_ack;
                if (w_wd_expire || (w_mask_nxt == 4'h0)) begin
                    w_state_nxt = w_wd_expire ? SEQ_RETIRE : SEQ_ENABLE;
                end
            end
            SEQ_ENABLE: begin
                if (w_wd_expire || w_ack[r_src]) begin
                    w_state_nxt = SEQ_RETIRE;
                end
            end
            SEQ_RETIRE: begin
                w_state_nxt = SEQ_IDLE;
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
            end
        endcase
        if (w_state_nxt == SEQ_RETIRE) begin
            w_mask_nxt = 4'h0;
        end
    end

    // Commands are computed from the next state so they line up with it
    // once registered.
    assign w_is_rd_nxt = w_latch ? w_type_rd : r_is_rd;
    assign w_src_nxt   = w_latch ? broad_cpu_id_i : r_src;

    always_comb begin
        w_cmd_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            if ((w_state_nxt == SEQ_SNOOP) && w_mask_nxt[i]) begin
                w_cmd_nxt[i] = CBUS_CMD_WIDTH'(w_is_rd_nxt ? CBUS_CMD_RD_SNOOP
                                                            : CBUS_CMD_WR_SNOOP);
            end else if ((w_state_nxt == SEQ_ENABLE) && (w_src_nxt == 2'(i))) begin
                w_cmd_nxt[i] = CBUS_CMD_WIDTH'(w_is_rd_nxt ? CBUS_CMD_EN_RD
                                                            : CBUS_CMD_EN_WR);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEQ_IDLE;
            r_mask  <= 4'h0;
            r_is_rd <= 1'b0;
            r_src   <= 2'd0;
            r_addr  <= '0;
            r_id    <= '0;
            r_pop   <= 1'b0;
            r_cmd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_is_rd <= w_is_rd_nxt;
            r_src   <= w_src_nxt;
            r_pop   <= (w_state_nxt == SEQ_RETIRE);
            r_cmd   <= w_cmd_nxt;
            if (w_latch) begin
                r_addr <= broad_addr_i;
                r_id   <= broad_id_i;
            end
        end
    end

    assign broad_pop_o = r_pop;
    assign cbus_addr_o = r_addr;
    assign active_id_o = r_id;
    assign busy_o      = (r_state != SEQ_IDLE);
    assign cbus_cmd3_o = r_cmd[3];
    assign cbus_cmd2_o = r_cmd[2];
    assign cbus_cmd1_o = r_cmd[1];
    assign cbus_cmd0_o = r_cmd[0];

endmodule

// File: tb/tb_mesi_isc_broad_sequencer.sv
module tb_mesi_isc_broad_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  btype;
    logic [1:0]  cpu;
    logic [4:0]  bid;
    logic [31:0] baddr;
    logic [3:0]  ack;
    logic        pop, busy, tmo;
    logic [31:0] addr;
    logic [4:0]  aid;
    logic [2:0]  c3, c2, c1, c0;
    logic [11:0] cmds;

    int n_vec = 0;
    int n_err = 0;

    assign cmds = {c3, c2, c1, c0};

    always #5 clk = ~clk;

    mesi_isc_broad_sequencer #(
        .ADDR_WIDTH(32), .CBUS_CMD_WIDTH(3), .BROAD_TYPE_WIDTH(2),
        .BROAD_ID_WIDTH(5), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .broad_valid_i(valid), .broad_type_i(btype), .broad_cpu_id_i(cpu),
        .broad_id_i(bid), .broad_addr_i(baddr), .broad_pop_o(pop),
        .cbus_addr_o(addr),
        .cbus_cmd3_o(c3), .cbus_cmd2_o(c2), .cbus_cmd1_o(c1), .cbus_cmd0_o(c0),
        .cbus_ack3_i(ack[3]), .cbus_ack2_i(ack[2]), .cbus_ack1_i(ack[1]), .cbus_ack0_i(ack[0]),
        .active_id_o(aid), .busy_o(busy), .timeout_o(tmo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; btype = 2'd0; cpu = 2'd0; bid = 5'd0; baddr = 32'd0; ack = 4'd0;
        step(); step();
        n_vec++; if (cmds !== 12'h000) begin n_err++; $display("FAIL reset_cmds got %h want %h", cmds, 12'h000); end
        n_vec++; if (pop !== 1'b0) begin n_err++; $display("FAIL reset_pop got %b want 0", pop); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", tmo); end
        n_vec++; if (addr !== 32'd0) begin n_err++; $display("FAIL reset_addr got %h want 0", addr); end
        n_vec++; if (aid !== 5'd0) begin n_err++; $display("FAIL reset_id got %h want 0", aid); end
        rst = 1'b0;
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    // WR from CPU2, every snooped CPU acks while its command is shown.
    task automatic test_wr_all_ack();
        logic [11:0] ec [4] = '{12'h209, 12'h0C0, 12'h000, 12'h000};
        logic        ep [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  ad [4] = '{4'b1011, 4'b0100, 4'b0000, 4'b0000};
        valid = 1'b1; btype = 2'd1; cpu = 2'd2; bid = 5'd5; baddr = 32'h0000_1000;
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++; if (cmds !== ec[k]) begin n_err++; $display("FAIL wr_cmds c%0d got %h want %h", k, cmds, ec[k]); end
            n_vec++; if (pop !== ep[k]) begin n_err++; $display("FAIL wr_pop c%0d got %b want %b", k, pop, ep[k]); end
            n_vec++; if (busy !== eb[k]) begin n_err++; $display("FAIL wr_busy c%0d got %b want %b", k, busy, eb[k]); end
            n_vec++; if (addr !== 32'h0000_1000) begin n_err++; $display("FAIL wr_addr c%0d got %h want 00001000", k, addr); end
            n_vec++; if (aid !== 5'd5) begin n_err++; $display("FAIL wr_id c%0d got %0d want 5", k, aid); end
            ack = ad[k];
            if (k == 2) valid = 1'b0;
        end
    endtask

    // RD from CPU0; CPU3 acks at +1 and holds, CPU1 at +3, CPU2 at +5.
    task automatic test_rd_stagger();
        logic [11:0] ec [9] = '{12'h490, 12'h490, 12'h090, 12'h090, 12'h080,
                                12'h080, 12'h004, 12'h000, 12'h000};
        logic [3:0]  ad [9] = '{4'b0000, 4'b1000, 4'b1001, 4'b1010, 4'b1000,
                                4'b1100, 4'b0001, 4'b0000, 4'b0000};
        int pops = 0;
        valid = 1'b1; btype = 2'd2; cpu = 2'd0; bid = 5'd9; baddr = 32'h2000_0040;
        for (int k = 0; k < 9; k++) begin
            step();
            n_vec++; if (cmds !== ec[k]) begin n_err++; $display("FAIL rd_cmds c%0d got %h want %h", k, cmds, ec[k]); end
            n_vec++; if (pop !== (k == 7)) begin n_err++; $display("FAIL rd_pop c%0d got %b want %b", k, pop, (k == 7)); end
            if (pop === 1'b1) pops++;
            ack = ad[k];
            if (k == 7) valid = 1'b0;
        end
        n_vec++; if (addr !== 32'h2000_0040) begin n_err++; $display("FAIL rd_addr got %h want 20000040", addr); end
        n_vec++; if (pops !== 1) begin n_err++; $display("FAIL rd_popcount got %0d want 1", pops); end
    endtask

    // WR from CPU1 then RD from CPU3 with valid held high throughout.
    task automatic test_back_to_back();
        logic [11:0] ec [8] = '{12'h241, 12'h018, 12'h000, 12'h000,
                                12'h092, 12'h800, 12'h000, 12'h000};
        logic [3:0]  ad [8] = '{4'b1101, 4'b0010, 4'b0000, 4'b0000,
                                4'b0111, 4'b1000, 4'b0000, 4'b0000};
        logic        eb [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int pops = 0;
        valid = 1'b1; btype = 2'd1; cpu = 2'd1; bid = 5'd1; baddr = 32'hA000_0100;
        for (int k = 0; k < 8; k++) begin
            step();
            n_vec++; if (cmds !== ec[k]) begin n_err++; $display("FAIL b2b_cmds c%0d got %h want %h", k, cmds, ec[k]); end
            n_vec++; if (pop !== ((k == 2) || (k == 6))) begin n_err++; $display("FAIL b2b_pop c%0d got %b", k, pop); end
            n_vec++; if (busy !== eb[k]) begin n_err++; $display("FAIL b2b_busy c%0d got %b want %b", k, busy, eb[k]); end
            n_vec++; if (addr !== ((k < 4) ? 32'hA000_0100 : 32'hB000_0200)) begin n_err++; $display("FAIL b2b_addr c%0d got %h", k, addr); end
            n_vec++; if (aid !== ((k < 4) ? 5'd1 : 5'd2)) begin n_err++; $display("FAIL b2b_id c%0d got %0d", k, aid); end
            if (pop === 1'b1) pops++;
            ack = ad[k];
            if (k == 2) begin btype = 2'd2; cpu = 2'd3; bid = 5'd2; baddr = 32'hB000_0200; end
            if (k == 6) valid = 1'b0;
        end
        n_vec++; if (pops !== 2) begin n_err++; $display("FAIL b2b_popcount got %0d want 2", pops); end
    endtask

    // NOP and reserved types are dropped with no bus commands.
    task automatic test_nop();
        logic [1:0] types [2] = '{2'd0, 2'd3};
        for (int t = 0; t < 2; t++) begin
            valid = 1'b1; btype = types[t]; cpu = 2'd1; bid = 5'd7; baddr = 32'hDEAD_BEEF;
            step();
            n_vec++; if (cmds !== 12'h000) begin n_err++; $display("FAIL nop_cmds t%0d got %h want 000", t, cmds); end
            n_vec++; if (pop !== 1'b1) begin n_err++; $display("FAIL nop_pop t%0d got %b want 1", t, pop); end
            n_vec++; if (addr !== 32'hB000_0200) begin n_err++; $display("FAIL nop_addr t%0d got %h want b0000200", t, addr); end
            n_vec++; if (aid !== 5'd2) begin n_err++; $display("FAIL nop_id t%0d got %0d want 2", t, aid); end
            valid = 1'b0;
            step();
            n_vec++; if (cmds !== 12'h000) begin n_err++; $display("FAIL nop_cmds2 t%0d got %h want 000", t, cmds); end
            n_vec++; if (pop !== 1'b0) begin n_err++; $display("FAIL nop_pop2 t%0d got %b want 0", t, pop); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL nop_busy t%0d got %b want 0", t, busy); end
        end
    endtask

    // Source never acks: ENABLE lasts 16 cycles, then forced retire.
    task automatic test_timeout();
        valid = 1'b1; btype = 2'd1; cpu = 2'd0; bid = 5'd3; baddr = 32'h0000_3000;
        step();
        n_vec++; if (cmds !== 12'h248) begin n_err++; $display("FAIL to_snoop got %h want 248", cmds); end
        ack = 4'b1110;
        step();
        ack = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) step();
            n_vec++; if (cmds !== 12'h003) begin n_err++; $display("FAIL to_enable c%0d got %h want 003", k, cmds); end
            n_vec++; if (pop !== 1'b0) begin n_err++; $display("FAIL to_pop c%0d got %b want 0", k, pop); end
            n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL to_early c%0d got %b want 0", k, tmo); end
        end
        step();
        n_vec++; if (cmds !== 12'h000) begin n_err++; $display("FAIL to_retire_cmds got %h want 000", cmds); end
        n_vec++; if (pop !== 1'b1) begin n_err++; $display("FAIL to_retire_pop got %b want 1", pop); end
        n_vec++; if (tmo !== 1'b1) begin n_err++; $display("FAIL to_flag got %b want 1", tmo); end
        valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_vec++; if (tmo !== 1'b1) begin n_err++; $display("FAIL to_sticky c%0d got %b want 1", k, tmo); end
            n_vec++; if (pop !== 1'b0) begin n_err++; $display("FAIL to_nopop c%0d got %b want 0", k, pop); end
        end
    endtask

    // Reset during SNOOP after one ack; entry is re-latched and re-snooped.
    task automatic test_reset_mid();
        valid = 1'b1; btype = 2'd2; cpu = 2'd1; bid = 5'd11; baddr = 32'h0000_4000;
        step();
        n_vec++; if (cmds !== 12'h482) begin n_err++; $display("FAIL rm_snoop got %h want 482", cmds); end
        ack = 4'b0001;
        step();
        n_vec++; if (cmds !== 12'h480) begin n_err++; $display("FAIL rm_partial got %h want 480", cmds); end
        ack = 4'b0000;
        #1 rst = 1'b1;
        #1;
        n_vec++; if (cmds !== 12'h000) begin n_err++; $display("FAIL rm_async_cmds got %h want 000", cmds); end
        n_vec++; if (pop !== 1'b0) begin n_err++; $display("FAIL rm_async_pop got %b want 0", pop); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_async_busy got %b want 0", busy); end
        n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL rm_async_timeout got %b want 0", tmo); end
        n_vec++; if ({addr, aid} !== 37'd0) begin n_err++; $display("FAIL rm_async_addr_id got %h want 0", {addr, aid}); end
        step();
        n_vec++; if ({cmds, pop} !== 13'd0) begin n_err++; $display("FAIL rm_held got %h want 0", {cmds, pop}); end
        rst = 1'b0;
        step();
        n_vec++; if (cmds !== 12'h482) begin n_err++; $display("FAIL rm_relatch got %h want 482", cmds); end
        n_vec++; if (addr !== 32'h0000_4000) begin n_err++; $display("FAIL rm_addr got %h want 00004000", addr); end
        n_vec++; if (aid !== 5'd11) begin n_err++; $display("FAIL rm_id got %0d want 11", aid); end
        ack = 4'b1101;
        step();
        n_vec++; if (cmds !== 12'h020) begin n_err++; $display("FAIL rm_enable got %h want 020", cmds); end
        ack = 4'b0010;
        step();
        n_vec++; if (pop !== 1'b1) begin n_err++; $display("FAIL rm_pop got %b want 1", pop); end
        ack = 4'b0000; valid = 1'b0;
        step();
        n_vec++; if ({pop, busy} !== 2'b00) begin n_err++; $display("FAIL rm_idle got %b want 00", {pop, busy}); end
    endtask

    initial begin
        test_reset();
        test_wr_all_ack();
        test_rd_stagger();
        test_back_to_back();
        test_nop();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
